// File: rtl/way3_scrub_ctrl_pkg.sv
// way3_scrub_ctrl_pkg: shared state encoding and sizing helpers for the scrub controller
package way3_scrub_ctrl_pkg;
  typedef logic [1:0] scrub_state_t;
  localparam scrub_state_t S_IDLE   = 2'd0;
  localparam scrub_state_t S_REQ    = 2'd1;
  localparam scrub_state_t S_VERIFY = 2'd2;
  localparam scrub_state_t S_FAIL   = 2'd3;
  function automatic int timer_w(input int ack_timeout);
    return $clog2(ack_timeout + 1);
  endfunction
endpackage

// File: rtl/way3_scrub_ctrl_if.sv
// way3_scrub_ctrl_if: voter-side inputs, scrub handshake and status bundle
interface way3_scrub_ctrl_if #(
  parameter int IN_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 en_i;
  logic [IN_WIDTH-1:0]  voted_i;
  logic                 error1_i;
  logic                 error2_i;
  logic                 clear_i;
  logic [CNT_WIDTH-1:0] threshold_i;
  logic                 scrub_req_o;
  logic [IN_WIDTH-1:0]  scrub_data_o;
  logic                 scrub_ack_i;
  logic [CNT_WIDTH-1:0] cnt1_o;
  logic [CNT_WIDTH-1:0] cnt2_o;
  logic                 fatal_o;
  logic                 timeout_o;
  logic                 irq_o;
  modport master (
    output en_i, voted_i, error1_i, error2_i, clear_i, threshold_i, scrub_ack_i,
    input  scrub_req_o, scrub_data_o, cnt1_o, cnt2_o, fatal_o, timeout_o, irq_o
  );
  modport slave (
    input  en_i, voted_i, error1_i, error2_i, clear_i, threshold_i, scrub_ack_i,
    output scrub_req_o, scrub_data_o, cnt1_o, cnt2_o, fatal_o, timeout_o, irq_o
  );
endinterface

// File: rtl/way3_scrub_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  // clear wins over increment; increment stops at saturation
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + WIDTH'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/way3_scrub_ctrl.sv
// way3_scrub_ctrl: requests replica rewrites after voter discrepancies and tracks scrub health
module way3_scrub_ctrl
  import way3_scrub_ctrl_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_RETRY   = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input logic            clk_i,
  input logic            rst_i,
  way3_scrub_ctrl_if.slave bus
);
  localparam int TW = timer_w(ACK_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  scrub_state_t         state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [IN_WIDTH-1:0]  data_q, data_d;
  logic                 req_q, req_d, fatal_q, fatal_d, timeout_q, timeout_d, irq_q, irq_d;
  logic                 err2_q, start, inc2, thr_hit;
  logic [CNT_WIDTH-1:0] cnt1, cnt2;
  assign start   = ~bus.clear_i & ~bus.error2_i & bus.en_i & bus.error1_i & (state_q == S_IDLE);
  assign inc2    = bus.error2_i & ~err2_q;
  assign thr_hit = start && cnt1 != '1 && bus.threshold_i != '0 && (cnt1 + CNT_WIDTH'(1)) == bus.threshold_i;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt1 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i), .inc_i(start), .cnt_o(cnt1)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt2 (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i), .inc_i(inc2), .cnt_o(cnt2)
  );
  // next state: clear, then no-majority, then ack, then ack timeout, then single discrepancy
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    data_d    = data_q;
    req_d     = req_q;
    fatal_d   = fatal_q;
    timeout_d = timeout_q;
    irq_d     = thr_hit;
    if (bus.clear_i) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      retry_d   = '0;
      req_d     = 1'b0;
      fatal_d   = 1'b0;
      timeout_d = 1'b0;
      irq_d     = 1'b0;
    end else if (bus.error2_i && state_q != S_FAIL) begin
      state_d = S_FAIL;
      req_d   = 1'b0;
      fatal_d = 1'b1;
      irq_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:
          if (start) begin
            state_d = S_REQ;
            data_d  = bus.voted_i;
            retry_d = RW'(1);
            timer_d = '0;
            req_d   = 1'b1;
          end
        S_REQ:
          if (bus.scrub_ack_i) begin
            state_d = S_VERIFY;
            req_d   = 1'b0;
          end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            timeout_d = 1'b1;
            irq_d     = 1'b1;
          end else timer_d = timer_q + TW'(1);
        S_VERIFY:
          if (!bus.error1_i) state_d = S_IDLE;
          else if (retry_q < RW'(MAX_RETRY)) begin
            state_d = S_REQ;
            data_d  = bus.voted_i;
            retry_d = retry_q + RW'(1);
            timer_d = '0;
            req_d   = 1'b1;
          end else begin
            state_d = S_FAIL;
            fatal_d = 1'b1;
            irq_d   = 1'b1;
          end
        default: state_d = state_q;
      endcase
    end
  end
  // state registers; reset drops the request without waiting for a clock
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      fatal_q   <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
      err2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      data_q    <= data_d;
      req_q     <= req_d;
      fatal_q   <= fatal_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
      err2_q    <= bus.error2_i;
    end
  assign bus.scrub_req_o  = req_q;
  assign bus.scrub_data_o = data_q;
  assign bus.cnt1_o       = cnt1;
  assign bus.cnt2_o       = cnt2;
  assign bus.fatal_o      = fatal_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.irq_o        = irq_q;
endmodule

// File: tb/tb_way3_scrub_ctrl.sv
// tb_way3_scrub_ctrl: scenario tasks with a transaction-level scrub model
module tb_way3_scrub_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  logic [CW-1:0] irq_cnt1 = '0;
  always #5 clk = ~clk;
  way3_scrub_ctrl_if #(.IN_WIDTH(32), .CNT_WIDTH(CW)) bus ();
  way3_scrub_ctrl #(.IN_WIDTH(32), .CNT_WIDTH(CW), .MAX_RETRY(2), .ACK_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  // count interrupt pulses and remember the event count each one arrived with
  always @(negedge clk)
    if (bus.irq_o === 1'b1) begin
      irq_cnt++;
      irq_cnt1 = bus.cnt1_o;
    end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_clear;
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
  endtask
  task automatic test_reset;
    bus.en_i = 1'b0; bus.voted_i = '0; bus.error1_i = 1'b0; bus.error2_i = 1'b0;
    bus.clear_i = 1'b0; bus.threshold_i = '0; bus.scrub_ack_i = 1'b0;
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o, bus.timeout_o, bus.irq_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {bus.scrub_req_o, bus.fatal_o, bus.timeout_o, bus.irq_o});
    end
    checks++;
    if (bus.scrub_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.scrub_data_o); end
    checks++;
    if (bus.cnt1_o !== '0) begin errors++; $display("FAIL reset_cnt1: got %0d want 0", bus.cnt1_o); end
    checks++;
    if (bus.cnt2_o !== '0) begin errors++; $display("FAIL reset_cnt2: got %0d want 0", bus.cnt2_o); end
  endtask
  task automatic test_single;
    int base = irq_cnt;
    logic [31:0] v = 32'hA5A5A5A5;
    bus.en_i = 1'b1; bus.threshold_i = '0; bus.voted_i = v; bus.error1_i = 1'b1;
    step();
    bus.error1_i = 1'b0; bus.voted_i = $urandom;
    checks++;
    if ({bus.scrub_req_o, bus.scrub_data_o} !== {1'b1, v}) begin
      errors++; $display("FAIL single_req: got req=%b data=%h want req=1 data=%h", bus.scrub_req_o, bus.scrub_data_o, v);
    end
    checks++;
    if (bus.cnt1_o !== CW'(1)) begin errors++; $display("FAIL single_cnt1: got %0d want 1", bus.cnt1_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      bus.voted_i = $urandom;
      checks++;
      if ({bus.scrub_req_o, bus.scrub_data_o} !== {1'b1, v}) begin
        errors++; $display("FAIL single_hold: got req=%b data=%h want req=1 data=%h", bus.scrub_req_o, bus.scrub_data_o, v);
      end
    end
    bus.scrub_ack_i = 1'b1;
    step();
    bus.scrub_ack_i = 1'b0;
    checks++;
    if (bus.scrub_req_o !== 1'b0) begin errors++; $display("FAIL single_ack: got req=%b want 0", bus.scrub_req_o); end
    step(2);
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o, bus.timeout_o} !== 3'b000 || bus.cnt1_o !== CW'(1) || irq_cnt != base) begin
      errors++; $display("FAIL single_done: got req/fatal/to=%b cnt1=%0d irqs=%0d want 000 1 0",
        {bus.scrub_req_o, bus.fatal_o, bus.timeout_o}, bus.cnt1_o, irq_cnt - base);
    end
  endtask
  task automatic test_retry_fatal;
    int base = irq_cnt;
    logic [31:0] v1 = $urandom;
    logic [31:0] v2 = ~v1;
    bus.voted_i = v1; bus.error1_i = 1'b1;
    step();
    checks++;
    if ({bus.scrub_req_o, bus.scrub_data_o} !== {1'b1, v1} || bus.cnt1_o !== CW'(2)) begin
      errors++; $display("FAIL retry_first: got req=%b data=%h cnt1=%0d want 1 %h 2", bus.scrub_req_o, bus.scrub_data_o, bus.cnt1_o, v1);
    end
    bus.scrub_ack_i = 1'b1;
    step();
    bus.scrub_ack_i = 1'b0; bus.voted_i = v2;
    checks++;
    if (bus.scrub_req_o !== 1'b0) begin errors++; $display("FAIL retry_verify1: got req=%b want 0", bus.scrub_req_o); end
    step();
    checks++;
    if ({bus.scrub_req_o, bus.scrub_data_o} !== {1'b1, v2} || bus.cnt1_o !== CW'(2)) begin
      errors++; $display("FAIL retry_second: got req=%b data=%h cnt1=%0d want 1 %h 2", bus.scrub_req_o, bus.scrub_data_o, bus.cnt1_o, v2);
    end
    step(2);
    bus.scrub_ack_i = 1'b1;
    step();
    bus.scrub_ack_i = 1'b0;
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o} !== 2'b00) begin
      errors++; $display("FAIL retry_verify2: got req/fatal=%b want 00", {bus.scrub_req_o, bus.fatal_o});
    end
    step();
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o} !== 2'b01) begin
      errors++; $display("FAIL retry_fatal: got req/fatal=%b want 01", {bus.scrub_req_o, bus.fatal_o});
    end
    step(3);
    checks++;
    if (bus.scrub_req_o !== 1'b0 || bus.cnt1_o !== CW'(2) || irq_cnt - base != 1) begin
      errors++; $display("FAIL retry_fail_hold: got req=%b cnt1=%0d irqs=%0d want 0 2 1", bus.scrub_req_o, bus.cnt1_o, irq_cnt - base);
    end
    bus.error1_i = 1'b0;
    do_clear();
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o, bus.timeout_o, bus.irq_o} !== 4'b0000 || bus.cnt1_o !== '0 || bus.cnt2_o !== '0) begin
      errors++; $display("FAIL retry_clear: got flags=%b cnt1=%0d cnt2=%0d want 0000 0 0",
        {bus.scrub_req_o, bus.fatal_o, bus.timeout_o, bus.irq_o}, bus.cnt1_o, bus.cnt2_o);
    end
  endtask
  task automatic test_timeout;
    int base = irq_cnt;
    int n = 0;
    bus.voted_i = $urandom; bus.error1_i = 1'b1;
    step();
    bus.error1_i = 1'b0;
    for (int i = 0; i < 40 && bus.scrub_req_o === 1'b1; i++) begin
      n++;
      step();
    end
    checks++;
    if (n != 15) begin errors++; $display("FAIL timeout_len: got %0d req cycles want 15", n); end
    checks++;
    if ({bus.timeout_o, bus.fatal_o} !== 2'b10 || bus.cnt1_o !== CW'(1)) begin
      errors++; $display("FAIL timeout_flags: got to/fatal=%b cnt1=%0d want 10 1", {bus.timeout_o, bus.fatal_o}, bus.cnt1_o);
    end
    bus.scrub_ack_i = 1'b1;
    step();
    bus.scrub_ack_i = 1'b0;
    step();
    checks++;
    if (bus.scrub_req_o !== 1'b0 || irq_cnt - base != 1) begin
      errors++; $display("FAIL timeout_after: got req=%b irqs=%0d want 0 1", bus.scrub_req_o, irq_cnt - base);
    end
  endtask
  task automatic test_error2;
    int base;
    do_clear();
    base = irq_cnt;
    bus.voted_i = $urandom; bus.error1_i = 1'b1;
    step();
    bus.error1_i = 1'b0;
    bus.error2_i = 1'b1; bus.scrub_ack_i = 1'b1;
    step();
    bus.error2_i = 1'b0; bus.scrub_ack_i = 1'b0;
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o} !== 2'b01 || bus.cnt2_o !== CW'(1)) begin
      errors++; $display("FAIL err2_enter: got req/fatal=%b cnt2=%0d want 01 1", {bus.scrub_req_o, bus.fatal_o}, bus.cnt2_o);
    end
    bus.error1_i = 1'b1;
    step(3);
    bus.error1_i = 1'b0;
    checks++;
    if (bus.scrub_req_o !== 1'b0 || bus.cnt1_o !== CW'(1)) begin
      errors++; $display("FAIL err2_fail_hold: got req=%b cnt1=%0d want 0 1", bus.scrub_req_o, bus.cnt1_o);
    end
    for (int i = 0; i < 2; i++) begin
      bus.error2_i = 1'b1;
      step();
      bus.error2_i = 1'b0;
      step();
    end
    checks++;
    if (bus.cnt2_o !== CW'(3) || irq_cnt - base != 1 || bus.fatal_o !== 1'b1) begin
      errors++; $display("FAIL err2_count: got cnt2=%0d irqs=%0d fatal=%b want 3 1 1", bus.cnt2_o, irq_cnt - base, bus.fatal_o);
    end
    do_clear();
  endtask
  task automatic test_threshold;
    int base;
    int exp_cnt = 0;
    logic [31:0] v;
    do_clear();
    base = irq_cnt;
    bus.threshold_i = CW'(3);
    for (int k = 0; k < 20; k++) begin
      v = $urandom;
      bus.voted_i = v; bus.error1_i = 1'b1;
      step();
      bus.error1_i = 1'b0; bus.voted_i = $urandom;
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      checks++;
      if ({bus.scrub_req_o, bus.scrub_data_o} !== {1'b1, v} || bus.cnt1_o !== CW'(exp_cnt)) begin
        errors++; $display("FAIL thr_scrub%0d: got req=%b data=%h cnt1=%0d want 1 %h %0d",
          k, bus.scrub_req_o, bus.scrub_data_o, bus.cnt1_o, v, exp_cnt);
      end
      step($urandom_range(0, 4));
      bus.scrub_ack_i = 1'b1;
      step();
      bus.scrub_ack_i = 1'b0;
      step();
    end
    step();
    checks++;
    if (irq_cnt - base != 1 || irq_cnt1 !== CW'(3)) begin
      errors++; $display("FAIL thr_irq: got irqs=%0d at cnt1=%0d want 1 at 3", irq_cnt - base, irq_cnt1);
    end
    checks++;
    if (bus.cnt1_o !== CW'(15) || bus.fatal_o !== 1'b0) begin
      errors++; $display("FAIL thr_sat: got cnt1=%0d fatal=%b want 15 0", bus.cnt1_o, bus.fatal_o);
    end
    bus.threshold_i = '0;
  endtask
  task automatic test_async_reset;
    do_clear();
    bus.voted_i = $urandom; bus.error1_i = 1'b1;
    step();
    bus.error1_i = 1'b0;
    checks++;
    if (bus.scrub_req_o !== 1'b1 || bus.cnt1_o !== CW'(1)) begin
      errors++; $display("FAIL arst_pre: got req=%b cnt1=%0d want 1 1", bus.scrub_req_o, bus.cnt1_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o, bus.timeout_o, bus.irq_o} !== 4'b0000 || bus.cnt1_o !== '0 || bus.scrub_data_o !== 32'h0) begin
      errors++; $display("FAIL arst_now: got flags=%b cnt1=%0d data=%h want 0000 0 0",
        {bus.scrub_req_o, bus.fatal_o, bus.timeout_o, bus.irq_o}, bus.cnt1_o, bus.scrub_data_o);
    end
    #3 rst = 1'b0;
    bus.scrub_ack_i = 1'b1;
    step();
    bus.scrub_ack_i = 1'b0;
    step(2);
    checks++;
    if ({bus.scrub_req_o, bus.fatal_o, bus.timeout_o} !== 3'b000 || bus.cnt1_o !== '0) begin
      errors++; $display("FAIL arst_ack: got req/fatal/to=%b cnt1=%0d want 000 0", {bus.scrub_req_o, bus.fatal_o, bus.timeout_o}, bus.cnt1_o);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_retry_fatal();
    test_timeout();
    test_error2();
    test_threshold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
